tracking_stream_arbiter: RTL and testbench

Frame-granular arbiter that shares one `tracking` engine between two pixel-stream requesters (camera/frame-buffer readers). A source wins the engine for one whole frame of WIDTH×HEIGHT pixels, and its pixels pass straight through to the engine's write port. The block then waits for the engine's bounding-box result, or a timeout, and reports the result tagged with the source ID. Sits between the stream producers and `tracking`, in the `clock_50` domain.

---
 rtl/tracking_stream_arbiter.sv | 161 ++++++++++++++++
 tb/tb_tracking_stream_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tracking_stream_arbiter.sv
// Frame-granular arbiter sharing one tracking engine between two pixel sources.
// A winning source streams one whole frame, then the engine result (or a timeout) is reported.
module tracking_stream_arbiter #(
    parameter int WIDTH          = 720,
    parameter int HEIGHT         = 540,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        s0_req,
    input  logic        s1_req,
    output logic        s0_grant,
    output logic        s1_grant,
    input  logic        s0_wr_en,
    input  logic        s1_wr_en,
    input  logic [23:0] s0_din,
    input  logic [23:0] s1_din,
    output logic        s0_full,
    output logic        s1_full,
    output logic        trk_wr_en,
    output logic [23:0] trk_din,
    input  logic        trk_full,
    input  logic        trk_valid,
    input  logic [11:0] trk_center_x,
    input  logic [11:0] trk_center_y,
    input  logic [11:0] trk_width,
    input  logic [11:0] trk_height,
    output logic        res_valid,
    output logic        res_src,
    output logic        res_timeout,
    output logic [11:0] res_center_x,
    output logic [11:0] res_center_y,
    output logic [11:0] res_width,
    output logic [11:0] res_height,
    output logic [7:0]  res_seq
);

    localparam int FRAME_PIXELS = WIDTH * HEIGHT;
    localparam int PIX_W = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(FRAME_PIXELS - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, STREAM, WAIT_RES, REPORT} state_t;

    state_t             state_q, state_d;
    logic               src_q, src_d;
    logic               last_src_q, last_src_d;
    logic [PIX_W-1:0]   pix_cnt_q, pix_cnt_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               res_src_q, res_src_d;
    logic               res_timeout_q, res_timeout_d;
    logic [47:0]        res_box_q, res_box_d;
    logic [7:0]         res_seq_q, res_seq_d;

    logic [1:0]         wr_w;
    logic [1:0]         grant_w;
    logic [1:0]         full_w;

    assign wr_w = {s1_wr_en, s0_wr_en};

    // Only the owner of the current frame sees the engine's backpressure; everyone else is held off.
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
        assign grant_w[gi] = (state_q == STREAM) && (src_q == 1'(gi));
        assign full_w[gi]  = grant_w[gi] ? trk_full : 1'b1;
    end

    assign s0_grant  = grant_w[0];
    assign s1_grant  = grant_w[1];
    assign s0_full   = full_w[0];
    assign s1_full   = full_w[1];
    assign trk_wr_en = (|(grant_w & wr_w)) & ~trk_full;
    assign trk_din   = grant_w[1] ? s1_din : (grant_w[0] ? s0_din : 24'd0);

    assign res_valid    = (state_q == REPORT);
    assign res_src      = res_src_q;
    assign res_timeout  = res_timeout_q;
    assign res_center_x = res_box_q[47:36];
    assign res_center_y = res_box_q[35:24];
    assign res_width    = res_box_q[23:12];
    assign res_height   = res_box_q[11:0];
    assign res_seq      = res_seq_q;

    always_comb begin
        state_d       = state_q;
        src_d         = src_q;
        last_src_d    = last_src_q;
        pix_cnt_d     = pix_cnt_q;
        timer_d       = timer_q;
        res_src_d     = res_src_q;
        res_timeout_d = res_timeout_q;
        res_box_d     = res_box_q;
        res_seq_d     = res_seq_q;
        case (state_q)
            IDLE: begin
                if (s0_req || s1_req) begin
                    // On contention the source that did not report last wins.
                    src_d     = (s0_req && s1_req) ? ~last_src_q : s1_req;
                    pix_cnt_d = '0;
                    state_d   = STREAM;
                end
            end
            STREAM: begin
                if (trk_wr_en) begin
                    if (pix_cnt_q == PIX_LAST) begin
                        timer_d = '0;
                        state_d = WAIT_RES;
                    end else begin
                        pix_cnt_d = pix_cnt_q + 1'b1;
                    end
                end
            end
            WAIT_RES: begin
                if (trk_valid) begin
                    res_box_d     = {trk_center_x, trk_center_y, trk_width, trk_height};
                    res_timeout_d = 1'b0;
                    res_src_d     = src_q;
                    state_d       = REPORT;
                end else if (timer_q == TMR_LAST) begin
                    res_box_d     = '0;
                    res_timeout_d = 1'b1;
                    res_src_d     = src_q;
                    state_d       = REPORT;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            REPORT: begin
                res_seq_d  = res_seq_q + 1'b1;
                last_src_d = res_src_q;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            src_q         <= 1'b0;
            last_src_q    <= 1'b1;
            pix_cnt_q     <= '0;
            timer_q       <= '0;
            res_src_q     <= 1'b0;
            res_timeout_q <= 1'b0;
            res_box_q     <= '0;
            res_seq_q     <= '0;
        end else begin
            state_q       <= state_d;
            src_q         <= src_d;
            last_src_q    <= last_src_d;
            pix_cnt_q     <= pix_cnt_d;
            timer_q       <= timer_d;
            res_src_q     <= res_src_d;
            res_timeout_q <= res_timeout_d;
            res_box_q     <= res_box_d;
            res_seq_q     <= res_seq_d;
        end
    end

endmodule

// File: tb/tb_tracking_stream_arbiter.sv
// Randomized frame-level bench for tracking_stream_arbiter with a stub tracking engine.
module tb_tracking_stream_arbiter;

    localparam int W    = 4;
    localparam int H    = 2;
    localparam int TO   = 16;
    localparam int NPIX = W * H;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        s0_req = 1'b0, s1_req = 1'b0;
    logic        s0_grant, s1_grant;
    logic        s0_wr_en = 1'b0, s1_wr_en = 1'b0;
    logic [23:0] s0_din = '0, s1_din = '0;
    logic        s0_full, s1_full;
    logic        trk_wr_en;
    logic [23:0] trk_din;
    logic        trk_full = 1'b0;
    logic        trk_valid = 1'b0;
    logic [11:0] trk_center_x = '0, trk_center_y = '0, trk_width = '0, trk_height = '0;
    logic        res_valid, res_src, res_timeout;
    logic [11:0] res_center_x, res_center_y, res_width, res_height;
    logic [7:0]  res_seq;

    tracking_stream_arbiter #(.WIDTH(W), .HEIGHT(H), .TIMEOUT_CYCLES(TO)) dut (
        .clock(clock), .reset(reset),
        .s0_req(s0_req), .s1_req(s1_req),
        .s0_grant(s0_grant), .s1_grant(s1_grant),
        .s0_wr_en(s0_wr_en), .s1_wr_en(s1_wr_en),
        .s0_din(s0_din), .s1_din(s1_din),
        .s0_full(s0_full), .s1_full(s1_full),
        .trk_wr_en(trk_wr_en), .trk_din(trk_din), .trk_full(trk_full),
        .trk_valid(trk_valid),
        .trk_center_x(trk_center_x), .trk_center_y(trk_center_y),
        .trk_width(trk_width), .trk_height(trk_height),
        .res_valid(res_valid), .res_src(res_src), .res_timeout(res_timeout),
        .res_center_x(res_center_x), .res_center_y(res_center_y),
        .res_width(res_width), .res_height(res_height),
        .res_seq(res_seq)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: who reported last, report counter, last reported box.
    bit          m_last = 1'b1;
    logic [7:0]  m_seq  = '0;
    logic [47:0] m_box  = '0;
    bit          m_to   = 1'b0;
    bit          m_src  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit pick(input bit r0, input bit r1, input bit last);
        if (r0 && r1) return ~last;
        return r1;
    endfunction

    task automatic quiet_inputs();
        s0_wr_en  = 1'b0;
        s1_wr_en  = 1'b0;
        trk_full  = 1'b0;
        trk_valid = 1'b0;
    endtask

    task automatic rand_box();
        trk_center_x = 12'($urandom);
        trk_center_y = 12'($urandom);
        trk_width    = 12'($urandom);
        trk_height   = 12'($urandom);
    endtask

    // Wait (bounded) for a grant after requests were driven; returns cycles taken.
    task automatic wait_grant(output int n);
        n = 0;
        do begin
            @(negedge clock);
            quiet_inputs();
            n++;
            #1;
        end while (!(s0_grant || s1_grant) && n < 4);
    endtask

    // vdelay: stub asserts trk_valid in the vdelay-th cycle after the last pixel (0 = never).
    task automatic run_frame(input bit r0, input bit r1, input int vdelay,
                             input bit rfull, input int r1_at);
        bit          exp_src;
        logic [23:0] pix [NPIX];
        logic [47:0] vbox;
        int          idx, n, exp_n;
        bit          wr, vhit;
        exp_src = pick(r0, r1, m_last);
        vbox    = '0;
        for (int i = 0; i < NPIX; i++) pix[i] = 24'($urandom);
        @(negedge clock);
        s0_req = r0;
        s1_req = r1;
        quiet_inputs();
        wait_grant(n);
        chk("grant_lat", n, 1);
        chk("grant_src", {s1_grant, s0_grant}, exp_src ? 2'b10 : 2'b01);

        idx = 0;
        n   = 0;
        while (idx < NPIX && n < 200) begin
            @(negedge clock);
            n++;
            wr = ($urandom % 4) != 0;
            if (exp_src == 1'b0) begin
                s0_wr_en = wr; s0_din = pix[idx];
                s1_wr_en = 1'b1; s1_din = 24'($urandom);
            end else begin
                s1_wr_en = wr; s1_din = pix[idx];
                s0_wr_en = 1'b1; s0_din = 24'($urandom);
            end
            trk_full  = rfull ? (($urandom % 3) == 0) : 1'b0;
            trk_valid = ($urandom % 5) == 0;
            rand_box();
            if (idx == r1_at) s1_req = 1'b1;
            #1;
            chk("stream_grant", {s1_grant, s0_grant}, exp_src ? 2'b10 : 2'b01);
            chk("own_full", exp_src ? s1_full : s0_full, trk_full);
            chk("other_full", exp_src ? s0_full : s1_full, 1);
            chk("trk_wr_en", trk_wr_en, wr & ~trk_full);
            if (trk_wr_en) begin
                chk("trk_din", trk_din, pix[idx]);
                idx++;
            end
        end
        chk("pix_count", idx, NPIX);

        n    = 0;
        vhit = (vdelay >= 1 && vdelay <= TO);
        while (n < 30) begin
            @(negedge clock);
            n++;
            s0_wr_en  = 1'b1;
            s1_wr_en  = 1'b1;
            trk_full  = 1'b0;
            trk_valid = (n == vdelay);
            rand_box();
            if (trk_valid && n <= TO) vbox = {trk_center_x, trk_center_y, trk_width, trk_height};
            #1;
            if (n == 1) begin
                chk("wait_grants", {s1_grant, s0_grant}, 2'b00);
                chk("wait_fulls", {s1_full, s0_full}, 2'b11);
                chk("wait_wr_en", trk_wr_en, 0);
            end
            if (res_valid) break;
        end
        exp_n = vhit ? vdelay + 1 : TO + 1;
        m_src = exp_src;
        m_to  = !vhit;
        m_box = vhit ? vbox : 48'd0;
        chk("report_cycle", n, exp_n);
        chk("res_valid", res_valid, 1);
        chk("res_src", res_src, m_src);
        chk("res_timeout", res_timeout, m_to);
        chk("res_box", {res_center_x, res_center_y, res_width, res_height}, m_box[31:0]);
        chk("res_box_hi", res_center_x, m_box[47:36]);
        chk("res_seq", res_seq, m_seq);
        $display("frame src=%0d timeout=%0d seq=%0d report_cycle=%0d", m_src, m_to, m_seq, n);

        @(negedge clock);
        s0_req = 1'b0;
        s1_req = 1'b0;
        quiet_inputs();
        trk_valid = 1'b1;
        rand_box();
        #1;
        m_seq  = m_seq + 8'd1;
        m_last = exp_src;
        chk("pulse_one", res_valid, 0);
        chk("seq_inc", res_seq, m_seq);
        chk("box_hold", {res_center_x, res_center_y, res_width, res_height}, m_box[31:0]);
        chk("src_hold", res_src, m_src);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit r0, r1;
        s0_req = 1'b1;
        s1_req = 1'b1;
        repeat (3) @(negedge clock);
        #1;
        chk("rst_grants", {s1_grant, s0_grant}, 2'b00);
        chk("rst_fulls", {s1_full, s0_full}, 2'b11);
        chk("rst_wr_en", trk_wr_en, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_src", res_src, 0);
        chk("rst_res_timeout", res_timeout, 0);
        chk("rst_box", {res_center_x, res_center_y, res_width, res_height}, 0);
        chk("rst_seq", res_seq, 0);
        @(negedge clock);
        s0_req = 1'b0;
        s1_req = 1'b0;
        reset  = 1'b0;

        run_frame(1, 1, 3, 0, -1);
        run_frame(1, 1, 5, 0, -1);
        run_frame(1, 0, 2, 1, -1);
        run_frame(0, 1, 0, 0, -1);
        run_frame(1, 0, TO, 0, -1);

        @(negedge clock);
        s0_req = 1'b1;
        s1_req = 1'b0;
        quiet_inputs();
        wait_grant(n);
        chk("mid_grant", s0_grant, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            s0_wr_en = 1'b1;
            s0_din   = 24'($urandom);
            #1;
            chk("mid_accept", trk_wr_en, 1);
        end
        @(negedge clock);
        s0_wr_en = 1'b0;
        s0_req   = 1'b0;
        reset    = 1'b1;
        @(negedge clock);
        #1;
        chk("mid_rst_grants", {s1_grant, s0_grant}, 2'b00);
        chk("mid_rst_fulls", {s1_full, s0_full}, 2'b11);
        chk("mid_rst_seq", res_seq, 0);
        $display("reset mid-frame after 3 pixels");
        reset  = 1'b0;
        m_last = 1'b1;
        m_seq  = '0;
        m_box  = '0;
        run_frame(1, 0, 4, 0, -1);

        run_frame(1, 0, 4, 0, 3);
        run_frame(1, 1, 2, 0, -1);
        run_frame(1, 1, 7, 1, -1);

        for (int k = 0; k < 20; k++) begin
            r0 = 1'($urandom);
            r1 = 1'($urandom);
            if (!r0 && !r1) r1 = 1'b1;
            run_frame(r0, r1, int'($urandom_range(0, TO + 1)), 1'($urandom), -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
